// File: rtl/ras_stack.sv
// Return-address stack: circular buffer of predicted return addresses with a
// registered pop response and a one-deep checkpoint for squash recovery.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop_valid,
    input  logic            ckpt_save,
    input  logic            ckpt_restore,
    output logic [XLEN-1:0] pop_addr,
    output logic            pop_hit,
    output logic [AW:0]     count,
    output logic            empty,
    output logic            full,
    output logic            ovf_pulse,
    output logic            unf_pulse
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [XLEN-1:0] stack [DEPTH];
    logic [AW-1:0]   tos;
    logic [AW-1:0]   tos_m1;
    logic [XLEN-1:0] top;

    logic [AW-1:0]   snap_tos;
    logic [AW:0]     snap_cnt;
    logic [XLEN-1:0] snap_top;

    logic [AW-1:0]   tos_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign tos_m1 = tos - AW'(1);
    assign top    = stack[tos_m1];

    // Restore wins over push/pop; push+pop on a live stack rewrites the top in place.
    always_comb begin
        tos_nxt = tos;
        cnt_nxt = count;
        wr_en   = 1'b0;
        wr_idx  = tos;
        wr_data = push_addr;
        if (ckpt_restore) begin
            tos_nxt = snap_tos;
            cnt_nxt = snap_cnt;
            wr_en   = 1'b1;
            wr_idx  = snap_tos - AW'(1);
            wr_data = snap_top;
        end else if (pop_valid && !empty) begin
            if (push_valid) begin
                wr_en  = 1'b1;
                wr_idx = tos_m1;
            end else begin
                tos_nxt = tos_m1;
                cnt_nxt = count - (AW+1)'(1);
            end
        end else if (push_valid) begin
            wr_en   = 1'b1;
            tos_nxt = tos + AW'(1);
            if (!full) begin
                cnt_nxt = count + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
            tos       <= '0;
            count     <= '0;
            pop_addr  <= '0;
            pop_hit   <= 1'b0;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
            snap_tos  <= '0;
            snap_cnt  <= '0;
            snap_top  <= '0;
        end else begin
            tos   <= tos_nxt;
            count <= cnt_nxt;
            if (wr_en) begin
                stack[wr_idx] <= wr_data;
            end
            if (ckpt_restore) begin
                pop_hit   <= 1'b0;
                ovf_pulse <= 1'b0;
                unf_pulse <= 1'b0;
            end else begin
                pop_hit   <= pop_valid && !empty;
                unf_pulse <= pop_valid && empty;
                ovf_pulse <= push_valid && !pop_valid && full;
                if (pop_valid) begin
                    pop_addr <= empty ? '0 : top;
                end
            end
            // Snapshot is always taken from pre-update state, so a same-cycle
            // restore still sees the previous snapshot.
            if (ckpt_save) begin
                snap_tos <= tos;
                snap_cnt <= count;
                snap_top <= top;
            end
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: directed scenarios with literal expectations plus a
// randomized command stream checked every cycle against a slot-array model.
module tb_ras_stack;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pv, po, cs, cr;
    logic [XLEN-1:0] pa;
    logic [XLEN-1:0] pop_addr;
    logic            pop_hit, empty, full, ovf_pulse, unf_pulse;
    logic [AW:0]     count;

    always #5 clk = ~clk;

    ras_stack #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(pv), .push_addr(pa), .pop_valid(po),
        .ckpt_save(cs), .ckpt_restore(cr),
        .pop_addr(pop_addr), .pop_hit(pop_hit), .count(count),
        .empty(empty), .full(full), .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: slot array indexed by a wrapping stack pointer, live-entry count.
    logic [31:0] m_mem [DEPTH];
    int          m_sp, m_cnt, s_sp, s_cnt;
    logic [31:0] s_top;
    logic [31:0] e_addr;
    logic        e_hit, e_ovf, e_unf;

    function automatic int wrap(input int v);
        return ((v % DEPTH) + DEPTH) % DEPTH;
    endfunction

    always @(posedge clk or posedge rst) begin
        int          o_sp, o_cnt;
        logic [31:0] o_top;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_sp = 0; m_cnt = 0; s_sp = 0; s_cnt = 0; s_top = 0;
            e_addr = 0; e_hit = 0; e_ovf = 0; e_unf = 0;
        end else begin
            o_sp  = m_sp;
            o_cnt = m_cnt;
            o_top = m_mem[wrap(m_sp - 1)];
            e_ovf = 0;
            e_unf = 0;
            if (cr) begin
                m_sp  = s_sp;
                m_cnt = s_cnt;
                m_mem[wrap(s_sp - 1)] = s_top;
                e_hit = 0;
            end else begin
                e_hit = 0;
                if (po) begin
                    if (o_cnt > 0) begin
                        e_addr = o_top;
                        e_hit  = 1;
                    end else begin
                        e_addr = 0;
                        e_unf  = 1;
                    end
                end
                if (po && o_cnt > 0) begin
                    if (pv) m_mem[wrap(o_sp - 1)] = pa;
                    else begin
                        m_sp  = wrap(o_sp - 1);
                        m_cnt = o_cnt - 1;
                    end
                end else if (pv) begin
                    if (o_cnt == DEPTH) e_ovf = 1;
                    m_mem[o_sp] = pa;
                    m_sp = wrap(o_sp + 1);
                    if (o_cnt < DEPTH) m_cnt = o_cnt + 1;
                end
            end
            if (cs) begin
                s_sp  = o_sp;
                s_cnt = o_cnt;
                s_top = o_top;
            end
        end
    end

    always @(negedge clk) begin
        chk("pop_addr", pop_addr, e_addr);
        chk("pop_hit", 32'(pop_hit), 32'(e_hit));
        chk("count", 32'(count), m_cnt);
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("ovf_pulse", 32'(ovf_pulse), 32'(e_ovf));
        chk("unf_pulse", 32'(unf_pulse), 32'(e_unf));
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic p,
                       input logic s, input logic r);
        pv = v; pa = a; po = p; cs = s; cr = r;
        @(negedge clk);
        pv = 0; po = 0; cs = 0; cr = 0;
    endtask

    initial begin
        pv = 0; pa = 0; po = 0; cs = 0; cr = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        chk("t1 count", 32'(count), 0);
        chk("t1 empty", 32'(empty), 1);
        chk("t1 hit", 32'(pop_hit), 0);
        cyc(0, 0, 1, 0, 0);
        chk("t1 pop hit", 32'(pop_hit), 0);
        chk("t1 unf", 32'(unf_pulse), 1);

        cyc(1, 32'h100, 0, 0, 0);
        cyc(1, 32'h200, 0, 0, 0);
        cyc(1, 32'h300, 0, 0, 0);
        chk("t2 count3", 32'(count), 3);
        cyc(0, 0, 1, 0, 0);
        chk("t2 pop1", pop_addr, 32'h300);
        chk("t2 hit1", 32'(pop_hit), 1);
        cyc(0, 0, 1, 0, 0);
        chk("t2 pop2", pop_addr, 32'h200);
        cyc(0, 0, 1, 0, 0);
        chk("t2 pop3", pop_addr, 32'h100);
        chk("t2 count0", 32'(count), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2 idle hit", 32'(pop_hit), 0);
        chk("t2 idle hold", pop_addr, 32'h100);
        cyc(0, 0, 1, 0, 0);
        chk("t2 pop4 hit", 32'(pop_hit), 0);
        chk("t2 pop4 unf", 32'(unf_pulse), 1);

        for (int i = 1; i <= 5; i++) begin
            cyc(1, 32'(i * 16), 0, 0, 0);
            chk("t3 ovf", 32'(ovf_pulse), 32'(i == 5));
        end
        chk("t3 full", 32'(full), 1);
        chk("t3 count", 32'(count), DEPTH);
        for (int i = 5; i >= 2; i--) begin
            cyc(0, 0, 1, 0, 0);
            chk("t3 pop", pop_addr, 32'(i * 16));
        end
        cyc(0, 0, 1, 0, 0);
        chk("t3 pop5 hit", 32'(pop_hit), 0);

        cyc(1, 32'hA0, 0, 0, 0);
        cyc(1, 32'hB0, 1, 0, 0);
        chk("t4 pop", pop_addr, 32'hA0);
        chk("t4 count", 32'(count), 1);
        cyc(0, 0, 1, 0, 0);
        chk("t4 pop2", pop_addr, 32'hB0);

        cyc(1, 32'h1000, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h2000, 0, 0, 0);
        cyc(1, 32'h3000, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5 count", 32'(count), 1);
        cyc(0, 0, 1, 0, 0);
        chk("t5 pop", pop_addr, 32'h1000);
        chk("t5 hit", 32'(pop_hit), 1);

        cyc(1, 32'h44, 0, 0, 0);
        po = 1;
        @(posedge clk);
        #2;
        po = 0;
        chk("t6 hit pre", 32'(pop_hit), 1);
        chk("t6 addr pre", pop_addr, 32'h44);
        rst = 1;
        #1;
        chk("t6 hit rst", 32'(pop_hit), 0);
        chk("t6 count rst", 32'(count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(0, 99) < 50, $urandom,
                $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
